// File: rtl/gmii_mux_n.sv
// N-port GMII receive multiplexer: frame-safe port switching with an optional
// per-port forwarded-frame counter bank (enabled by GMII_MUX_N_FRAME_CNT_EN).

module gmii_mux_n_cnt (
  input  logic        aclk,
  input  logic        arstn,
  input  logic        inc,
  output logic [31:0] value
);
  always_ff @(posedge aclk) begin
    if (!arstn)   value <= '0;
    else if (inc) value <= value + 32'd1;
  end
endmodule

module gmii_mux_n #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 8,
  parameter int SEL_W      = 4
) (
  input  logic                            aclk,
  input  logic                            arstn,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0] in_rxd,
  input  logic [NUM_PORTS-1:0]            in_rx_dv,
  input  logic [NUM_PORTS-1:0]            in_rx_er,
  input  logic [SEL_W-1:0]                sel_req,
  output logic [DATA_WIDTH-1:0]           out_rxd,
  output logic                            out_rx_dv,
  output logic                            out_rx_er,
  output logic [SEL_W-1:0]                sel_active,
  output logic                            switching,
  input  logic [SEL_W-1:0]                cnt_sel,
  output logic [31:0]                     cnt_value
);
  typedef enum logic [1:0] {S_OFF, S_FWD, S_DRAIN} state_t;

  localparam logic [SEL_W-1:0] SEL_NONE = '1;
  localparam logic [SEL_W-1:0] SEL_NP   = SEL_W'(NUM_PORTS);

  state_t                               state;
  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] rxd_v;
  logic                                 req_ok;
  logic [SEL_W-1:0]                     req_norm;
  logic [DATA_WIDTH-1:0]                act_rxd;
  logic                                 act_dv, act_er, req_dv;

  assign rxd_v    = in_rxd;
  assign req_ok   = sel_req < SEL_NP;
  assign req_norm = req_ok ? sel_req : SEL_NONE;

  // Compare-based lookup keeps out-of-range selects harmless.
  always_comb begin
    act_rxd = '0;
    act_dv  = 1'b0;
    act_er  = 1'b0;
    req_dv  = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel_active == SEL_W'(i)) begin
        act_rxd = rxd_v[i];
        act_dv  = in_rx_dv[i];
        act_er  = in_rx_er[i];
      end
      if (sel_req == SEL_W'(i)) req_dv = in_rx_dv[i];
    end
  end

  always_ff @(posedge aclk) begin
    if (!arstn) begin
      state      <= S_OFF;
      sel_active <= SEL_NONE;
      out_rxd    <= '0;
      out_rx_dv  <= 1'b0;
      out_rx_er  <= 1'b0;
    end else begin
      out_rxd   <= '0;
      out_rx_dv <= 1'b0;
      out_rx_er <= 1'b0;
      case (state)
        S_OFF: if (req_ok) state <= S_DRAIN;
        S_FWD: begin
          out_rxd   <= act_rxd;
          out_rx_dv <= act_dv;
          out_rx_er <= act_er;
          // Only leave between frames of the active port.
          if (req_norm != sel_active && !act_dv) state <= S_DRAIN;
        end
        S_DRAIN: begin
          if (!req_ok) begin
            state      <= S_OFF;
            sel_active <= SEL_NONE;
          end else if (!req_dv) begin
            state      <= S_FWD;
            sel_active <= sel_req;
          end
        end
        default: state <= S_OFF;
      endcase
    end
  end

  assign switching = (req_norm != sel_active) || (state == S_DRAIN);

`ifdef GMII_MUX_N_FRAME_CNT_EN
  logic [NUM_PORTS-1:0]       cnt_inc;
  logic [NUM_PORTS-1:0][31:0] cnt_q;

  // A frame is counted when out_rx_dv is about to rise.
  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_cnt
    assign cnt_inc[g] = (state == S_FWD) && act_dv && !out_rx_dv &&
                        (sel_active == SEL_W'(g));
    gmii_mux_n_cnt u_cnt (
      .aclk  (aclk),
      .arstn (arstn),
      .inc   (cnt_inc[g]),
      .value (cnt_q[g])
    );
  end

  always_comb begin
    cnt_value = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      if (cnt_sel == SEL_W'(i)) cnt_value = cnt_q[i];
  end
`else
  logic unused_cnt_sel;
  assign unused_cnt_sel = ^cnt_sel;
  assign cnt_value      = '0;
`endif

endmodule

// File: tb/tb_gmii_mux_n.sv
// Self-checking bench for gmii_mux_n: directed scenarios with literal
// expectations, then randomized traffic against a behavioural port model.

module tb_gmii_mux_n;
  localparam int NP = 4;
  localparam int DW = 8;
  localparam int SW = 4;

  logic                   aclk = 1'b0;
  logic                   arstn;
  logic [NP-1:0][DW-1:0]  d_p;
  logic [NP*DW-1:0]       in_rxd;
  logic [NP-1:0]          in_rx_dv, in_rx_er;
  logic [SW-1:0]          sel_req, cnt_sel;
  logic [DW-1:0]          out_rxd;
  logic                   out_rx_dv, out_rx_er, switching;
  logic [SW-1:0]          sel_active;
  logic [31:0]            cnt_value;

  assign in_rxd = d_p;

  gmii_mux_n #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .SEL_W(SW)) dut (
    .aclk(aclk), .arstn(arstn), .in_rxd(in_rxd), .in_rx_dv(in_rx_dv),
    .in_rx_er(in_rx_er), .sel_req(sel_req), .out_rxd(out_rxd),
    .out_rx_dv(out_rx_dv), .out_rx_er(out_rx_er), .sel_active(sel_active),
    .switching(switching), .cnt_sel(cnt_sel), .cnt_value(cnt_value)
  );

  always #5 aclk = ~aclk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: which port is forwarded (-1 = none), whether a change is pending,
  // the one-cycle-late output word and per-port frame totals.
  int          m_cur   = -1;
  bit          m_drain = 1'b0;
  logic [DW-1:0] e_d   = '0;
  logic        e_dv    = 1'b0;
  logic        e_er    = 1'b0;
  logic [31:0] m_cnt [NP];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int req_port();
    return (int'(sel_req) < NP) ? int'(sel_req) : -1;
  endfunction

  task automatic model_update();
    int  req;
    bit  prev_dv;
    req = req_port();
    if (!arstn) begin
      m_cur = -1; m_drain = 1'b0;
      e_d = '0; e_dv = 1'b0; e_er = 1'b0;
      for (int p = 0; p < NP; p++) m_cnt[p] = '0;
    end else begin
      prev_dv = e_dv;
      if (!m_drain && m_cur >= 0) begin
        e_d = d_p[m_cur]; e_dv = in_rx_dv[m_cur]; e_er = in_rx_er[m_cur];
        if (e_dv && !prev_dv) m_cnt[m_cur] = m_cnt[m_cur] + 32'd1;
      end else begin
        e_d = '0; e_dv = 1'b0; e_er = 1'b0;
      end
      if (!m_drain && m_cur < 0) begin
        if (req >= 0) m_drain = 1'b1;
      end else if (!m_drain) begin
        if (req != m_cur && !in_rx_dv[m_cur]) m_drain = 1'b1;
      end else if (req < 0) begin
        m_drain = 1'b0; m_cur = -1;
      end else if (!in_rx_dv[req]) begin
        m_drain = 1'b0; m_cur = req;
      end
    end
  endtask

  // One clock: check combinational outputs, advance the model, check registers.
  task automatic step();
    logic [31:0] exp_cnt;
    #1;
    chk("switching", {31'd0, switching}, {31'd0, (m_drain || req_port() != m_cur)});
    exp_cnt = '0;
`ifdef GMII_MUX_N_FRAME_CNT_EN
    if (int'(cnt_sel) < NP) exp_cnt = m_cnt[cnt_sel];
`endif
    chk("cnt_value", cnt_value, exp_cnt);
    model_update();
    @(posedge aclk);
    #1;
    chk("out_rxd",    {24'd0, out_rxd}, {24'd0, e_d});
    chk("out_rx_dv",  {31'd0, out_rx_dv}, {31'd0, e_dv});
    chk("out_rx_er",  {31'd0, out_rx_er}, {31'd0, e_er});
    chk("sel_active", {28'd0, sel_active}, (m_cur < 0) ? 32'hF : m_cur);
    @(negedge aclk);
  endtask

  task automatic idle_all();
    in_rx_dv = '0; in_rx_er = '0; d_p = '0;
  endtask

  function automatic logic [31:0] cnt_exp(input logic [31:0] v);
`ifdef GMII_MUX_N_FRAME_CNT_EN
    return v;
`else
    return 32'd0 & v;
`endif
  endfunction

  int rem [NP];
  int gap [NP];

  initial begin
    for (int p = 0; p < NP; p++) begin m_cnt[p] = '0; rem[p] = 0; gap[p] = 0; end
    arstn = 1'b0; sel_req = 4'd4; cnt_sel = 4'd0;
    idle_all();
    @(negedge aclk);
    step(); step();
    chk("rst_sel_active", {28'd0, sel_active}, 32'hF);
    chk("rst_out_rx_dv", {31'd0, out_rx_dv}, 32'd0);
    chk("rst_switching", {31'd0, switching}, 32'd0);
    chk("rst_cnt_value", cnt_value, 32'd0);

    // Select port 1 while idle: active two clocks later.
    arstn = 1'b1; sel_req = 4'd1;
    step(); step();
    chk("sel1_active", {28'd0, sel_active}, 32'd1);

    // 64-byte frame on port 1, byte-exact one cycle late.
    for (int k = 0; k < 64; k++) begin
      in_rx_dv[1] = 1'b1; d_p[1] = DW'(k + 16);
      step();
      if (k == 0)  chk("f1_first_byte", {24'd0, out_rxd}, 32'h10);
      if (k == 63) chk("f1_last_byte",  {24'd0, out_rxd}, 32'h4F);
    end
    idle_all(); step();
    chk("f1_end_dv", {31'd0, out_rx_dv}, 32'd0);
    cnt_sel = 4'd1; #1;
    chk("f1_cnt", cnt_value, cnt_exp(32'd1));

    // Change 1 -> 2 mid-frame: frame completes, then port 2 takes over.
    for (int k = 0; k < 20; k++) begin
      in_rx_dv[1] = 1'b1; d_p[1] = DW'(k * 3);
      if (k == 5) sel_req = 4'd2;
      step();
      if (k == 10) begin
        chk("mid_switching", {31'd0, switching}, 32'd1);
        chk("mid_sel_active", {28'd0, sel_active}, 32'd1);
        chk("mid_dv", {31'd0, out_rx_dv}, 32'd1);
      end
    end
    idle_all(); step(); step();
    chk("sel2_active", {28'd0, sel_active}, 32'd2);
    chk("sel2_switching", {31'd0, switching}, 32'd0);

    // Switch to port 3 while it is mid-frame: that frame is skipped.
    sel_req = 4'd3;
    for (int k = 0; k < 10; k++) begin
      in_rx_dv[3] = 1'b1; d_p[3] = 8'hA0 + DW'(k);
      step();
      if (k == 6) begin
        chk("skip_dv", {31'd0, out_rx_dv}, 32'd0);
        chk("skip_switching", {31'd0, switching}, 32'd1);
      end
    end
    idle_all(); step();
    chk("sel3_active", {28'd0, sel_active}, 32'd3);
    for (int k = 0; k < 8; k++) begin
      in_rx_dv[3] = 1'b1; d_p[3] = 8'h50 + DW'(k);
      step();
      if (k == 0) chk("f3_first", {23'd0, out_rx_dv, out_rxd}, 32'h150);
    end
    idle_all(); step();

    // No-port select: OFF, frames ignored.
    sel_req = 4'd4;
    step(); step();
    chk("off_sel_active", {28'd0, sel_active}, 32'hF);
    for (int k = 0; k < 6; k++) begin
      in_rx_dv[0] = 1'b1; d_p[0] = DW'(k + 1);
      step();
    end
    chk("off_dv", {31'd0, out_rx_dv}, 32'd0);
    chk("off_switching", {31'd0, switching}, 32'd0);
    idle_all(); step();

    // Five frames from port 0.
    sel_req = 4'd0;
    step(); step();
    for (int f = 0; f < 5; f++) begin
      for (int k = 0; k < 4; k++) begin
        in_rx_dv[0] = 1'b1; d_p[0] = DW'(f * 16 + k);
        step();
      end
      idle_all(); step(); step();
    end
    cnt_sel = 4'd0; #1; chk("cnt_p0", cnt_value, cnt_exp(32'd5));
    cnt_sel = 4'd2; #1; chk("cnt_p2", cnt_value, 32'd0);
    cnt_sel = 4'd1; #1; chk("cnt_p1", cnt_value, cnt_exp(32'd2));
    cnt_sel = 4'd7; #1; chk("cnt_oob", cnt_value, 32'd0);
    cnt_sel = 4'd0;
    @(negedge aclk);

    // One-cycle reset in the middle of a port-0 frame.
    for (int k = 0; k < 10; k++) begin
      in_rx_dv[0] = 1'b1; d_p[0] = 8'hC0 + DW'(k);
      arstn = (k != 4);
      step();
      if (k == 4) begin
        chk("mrst_dv", {31'd0, out_rx_dv}, 32'd0);
        chk("mrst_sel_active", {28'd0, sel_active}, 32'hF);
        chk("mrst_cnt", cnt_value, 32'd0);
      end
      if (k > 4) chk("mrst_no_glitch", {31'd0, out_rx_dv}, 32'd0);
    end
    arstn = 1'b1;
    idle_all(); step();

    // Randomized traffic against the model.
    for (int c = 0; c < 4000; c++) begin
      for (int p = 0; p < NP; p++) begin
        if (rem[p] == 0 && gap[p] == 0) begin
          rem[p] = $urandom_range(1, 40);
          gap[p] = $urandom_range(1, 12);
        end
        d_p[p] = DW'($urandom);
        if (rem[p] > 0) begin
          in_rx_dv[p] = 1'b1; in_rx_er[p] = ($urandom_range(0, 63) == 0); rem[p]--;
        end else begin
          in_rx_dv[p] = 1'b0; in_rx_er[p] = 1'b0; gap[p]--;
        end
      end
      if ($urandom_range(0, 39) == 0) sel_req = SW'($urandom_range(0, 15));
      cnt_sel = SW'($urandom_range(0, 7));
      arstn = ($urandom_range(0, 499) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
